// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Sequences instruction fetch between the imem port and the prefetch buffer.
// Keeps at most one 32-bit word request outstanding. Completed words go
// straight through to the buffer write side with no added latency.
//
// Branch, jump and trap redirects do three things:
//   - clear the buffer
//   - select the halfword alignment of the first instruction
//   - discard any response that belongs to the pre-redirect stream
//
// Parameters
//   reset_pc        first fetch address after reset (word aligned)
//
// Ports
//   clock           single clock; all state updates on posedge
//   reset           asynchronous, active-low reset
//   redirect_valid  redirect request this cycle
//   redirect_addr   redirect target; bit 0 ignored, bit 1 selects upper halfword
//   buf_stall       registered stall from the prefetch buffer
//   mem_ready       imem response valid for the outstanding request
//   mem_rdata       imem read data, valid with mem_ready
//   mem_error       imem access fault, valid with mem_ready
//   mem_valid       request outstanding (registered)
//   mem_addr        word address of the request, [1:0] always 0 (registered)
//   buf_ready       write the current response into the buffer this cycle
//   buf_pc          address of the delivered word
//   buf_rdata       delivered word
//   buf_error       delivered fault flag
//   buf_clear       flush the buffer
//   buf_align       buffer starts reading at the upper halfword
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] reset_pc = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   input  logic        buf_stall,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_error,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic        buf_ready,
   output logic [31:0] buf_pc,
   output logic [31:0] buf_rdata,
   output logic        buf_error,
   output logic        buf_clear,
   output logic        buf_align
);

   // StIdle:  no request outstanding
   // StReq:   request outstanding, its response is wanted
   // StDrain: request outstanding, its response is stale and will be dropped
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StDrain = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] mem_addr_q, mem_addr_d;

   logic [31:0] tgt;
   logic [31:0] tgt_inc;
   logic [31:0] fetch_pc_inc;
   logic        unused_addr_bit0;

   // Bit 0 of the target never matters: instructions are at least halfword sized.
   assign unused_addr_bit0 = redirect_addr[0];

   assign tgt          = {redirect_addr[31:2], 2'b00};
   assign tgt_inc      = tgt + 32'd4;
   assign fetch_pc_inc = fetch_pc_q + 32'd4;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= reset_pc;
         mem_addr_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. A redirect takes priority over every other event.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;

      unique case (state_q)
         StIdle: begin
            if (redirect_valid) begin
               mem_addr_d = tgt;
               fetch_pc_d = tgt_inc;
               state_d    = StReq;
            end else if (!buf_stall) begin
               mem_addr_d = fetch_pc_q;
               fetch_pc_d = fetch_pc_inc;
               state_d    = StReq;
            end
         end

         StReq: begin
            if (redirect_valid) begin
               if (mem_ready) begin
                  // The bus is free again, so the target is issued right away.
                  mem_addr_d = tgt;
                  fetch_pc_d = tgt_inc;
               end else begin
                  // mem_addr must stay stable until the old request completes.
                  fetch_pc_d = tgt;
                  state_d    = StDrain;
               end
            end else if (mem_ready) begin
               if (buf_stall) begin
                  // The buffer refused the word, so rewind and fetch it again.
                  fetch_pc_d = mem_addr_q;
                  state_d    = StIdle;
               end else begin
                  mem_addr_d = fetch_pc_q;
                  fetch_pc_d = fetch_pc_inc;
               end
            end
         end

         StDrain: begin
            // The latest redirect target is kept, even if the stale response
            // lands in the same cycle.
            if (redirect_valid) begin
               fetch_pc_d = tgt;
            end
            if (mem_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign mem_valid = (state_q != StIdle);
   assign mem_addr  = mem_addr_q;

   // Combinational outputs are gated with reset so that they read 0 while
   // reset is held.
   assign buf_ready = reset & (state_q == StReq) & mem_ready & ~redirect_valid & ~buf_stall;
   assign buf_pc    = reset ? mem_addr_q : 32'h0000_0000;
   assign buf_rdata = reset ? mem_rdata  : 32'h0000_0000;
   assign buf_error = reset & mem_error;
   assign buf_clear = reset & redirect_valid;
   assign buf_align = reset & redirect_valid & redirect_addr[1];

endmodule
